// File: rtl/multi_channel_edge_trigger_if.sv
// rtl/multi_channel_edge_trigger_if.sv - sample, trigger configuration and trigger status bundle
interface multi_channel_edge_trigger_if #(
    parameter int DW  = 14,
    parameter int NCH = 2,
    parameter int HW  = 16
);
    localparam int CSW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;

    logic [NCH*DW-1:0]    adc_dat;
    logic [CSW-1:0]       ch_sel;
    logic signed [DW-1:0] threshold;
    logic [DW-1:0]        hysteresis;
    logic                 trig_edge;
    logic                 single_shot;
    logic                 arm;
    logic [HW-1:0]        holdoff;
    logic                 trig_out;
    logic                 armed;
    logic [31:0]          trig_cnt;

    modport master (
        output adc_dat, ch_sel, threshold, hysteresis, trig_edge, single_shot, arm, holdoff,
        input  trig_out, armed, trig_cnt
    );

    modport slave (
        input  adc_dat, ch_sel, threshold, hysteresis, trig_edge, single_shot, arm, holdoff,
        output trig_out, armed, trig_cnt
    );
endinterface

// File: rtl/multi_channel_edge_trigger.sv
// rtl/multi_channel_edge_trigger.sv - hysteresis edge trigger on one selectable ADC channel
module multi_channel_edge_trigger #(
    parameter int DW  = 14,
    parameter int NCH = 2,
    parameter int HW  = 16
) (
    input logic                         adc_clk,
    input logic                         adc_rst,
    multi_channel_edge_trigger_if.slave trig
);
    localparam int CSW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;
    localparam int CW  = DW + 2;

    typedef enum logic [1:0] {IDLE, WAIT_PRE, WAIT_CROSS, HOLDOFF} state_t;

    state_t               state, state_nx;
    logic signed [DW-1:0] s1, sample, cfg_thr;
    logic [CSW-1:0]       cfg_ch, sel_raw;
    logic [DW-1:0]        cfg_hyst;
    logic                 cfg_edge, cfg_ss;
    logic [HW-1:0]        cfg_hold, hcnt, hcnt_nx;
    logic                 arm_q, fresh, arm_rise, latch_cfg;
    logic                 fire, fire_q, trig_q;
    logic [31:0]          cnt;
    logic signed [CW-1:0] s1_x, thr_x, hyst_x, lo, hi;
    logic                 pre_ok, cross_ok;

    // While idle the live selection feeds S1 so the first armed compare already sees the new channel.
    assign sel_raw = (state == IDLE) ? trig.ch_sel : cfg_ch;

    always_comb begin
        sample = trig.adc_dat[DW-1:0];
        for (int k = 1; k < NCH; k++) begin
            if (32'(sel_raw) == 32'(k)) sample = trig.adc_dat[k*DW +: DW];
        end
    end

    assign s1_x   = {{2{s1[DW-1]}}, s1};
    assign thr_x  = {{2{cfg_thr[DW-1]}}, cfg_thr};
    assign hyst_x = {2'b00, cfg_hyst};
    assign lo     = thr_x - hyst_x;
    assign hi     = thr_x + hyst_x;

    assign pre_ok   = cfg_edge ? (s1_x < lo) : (s1_x > hi);
    assign cross_ok = cfg_edge ? (s1_x >= thr_x) : (s1_x <= thr_x);

    // fresh blocks an arm level held high across reset release from looking like an edge.
    assign arm_rise = trig.arm && !arm_q && !fresh;

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state <= IDLE;
            hcnt  <= '0;
        end else begin
            state <= state_nx;
            hcnt  <= hcnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        hcnt_nx   = hcnt;
        fire      = 1'b0;
        latch_cfg = 1'b0;
        case (state)
            IDLE: begin
                if (arm_rise) begin
                    latch_cfg = 1'b1;
                    state_nx  = WAIT_PRE;
                end
            end
            WAIT_PRE: begin
                if (pre_ok) state_nx = WAIT_CROSS;
            end
            WAIT_CROSS: begin
                if (cross_ok) begin
                    fire = 1'b1;
                    if (cfg_hold != '0) begin
                        state_nx = HOLDOFF;
                        hcnt_nx  = cfg_hold - HW'(1);
                    end else begin
                        state_nx = cfg_ss ? IDLE : WAIT_PRE;
                    end
                end
            end
            HOLDOFF: begin
                if (hcnt == '0) state_nx = cfg_ss ? IDLE : WAIT_PRE;
                else            hcnt_nx  = hcnt - HW'(1);
            end
            default: state_nx = IDLE;
        endcase
        if (state != IDLE && !trig.arm) state_nx = IDLE;
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            s1       <= '0;
            arm_q    <= 1'b0;
            fresh    <= 1'b1;
            fire_q   <= 1'b0;
            trig_q   <= 1'b0;
            cnt      <= '0;
            cfg_ch   <= '0;
            cfg_thr  <= '0;
            cfg_hyst <= '0;
            cfg_edge <= 1'b0;
            cfg_ss   <= 1'b0;
            cfg_hold <= '0;
        end else begin
            s1     <= sample;
            arm_q  <= trig.arm;
            fresh  <= 1'b0;
            fire_q <= fire;
            trig_q <= fire_q;
            if (fire_q) cnt <= cnt + 32'd1;
            if (latch_cfg) begin
                cfg_ch   <= trig.ch_sel;
                cfg_thr  <= trig.threshold;
                cfg_hyst <= trig.hysteresis;
                cfg_edge <= trig.trig_edge;
                cfg_ss   <= trig.single_shot;
                cfg_hold <= trig.holdoff;
            end
        end
    end

    assign trig.trig_out = trig_q;
    assign trig.armed    = (state == WAIT_PRE) || (state == WAIT_CROSS);
    assign trig.trig_cnt = cnt;
endmodule

// File: tb/tb_multi_channel_edge_trigger.sv
// tb/tb_multi_channel_edge_trigger.sv - scoreboard bench for multi_channel_edge_trigger
module tb_multi_channel_edge_trigger;
    localparam int DW  = 14;
    localparam int NCH = 2;
    localparam int HW  = 16;
    localparam int CSW = 1;

    logic adc_clk = 1'b0;
    logic adc_rst = 1'b1;
    always #5 adc_clk = ~adc_clk;

    multi_channel_edge_trigger_if #(.DW(DW), .NCH(NCH), .HW(HW)) bus ();

    multi_channel_edge_trigger #(.DW(DW), .NCH(NCH), .HW(HW)) dut (
        .adc_clk (adc_clk),
        .adc_rst (adc_rst),
        .trig    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int ch0_v = 0, ch1_v = 0, thr_v = 0, hyst_v = 0, hold_v = 0, sel_v = 0;
    bit edge_v = 1'b0, ss_v = 1'b0, arm_v = 1'b0;

    int m_st = 0, m_s1 = 0, m_hcnt = 0;
    int c_sel = 0, c_thr = 0, c_hyst = 0, c_hold = 0;
    bit c_edge = 1'b0, c_ss = 1'b0, m_armq = 1'b0, m_fresh = 1'b1;
    bit pipe[$];
    int exp_cnt = 0;

    int cyc = 0, pulses = 0, first_pulse = -1, last_pulse = -1, min_gap = 1000;
    int seq[$];

    task automatic check(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int pick(input int ch);
        return (ch == 1) ? ch1_v : ch0_v;
    endfunction

    task automatic step();
        bit fire, exp_trig, pre, crs;
        int nst, lo, hi;
        bus.adc_dat     = {ch1_v[DW-1:0], ch0_v[DW-1:0]};
        bus.ch_sel      = CSW'(sel_v);
        bus.threshold   = thr_v[DW-1:0];
        bus.hysteresis  = hyst_v[DW-1:0];
        bus.trig_edge   = edge_v;
        bus.single_shot = ss_v;
        bus.arm         = arm_v;
        bus.holdoff     = hold_v[HW-1:0];
        fire = 1'b0;
        if (adc_rst) begin
            m_st = 0; m_s1 = 0; m_hcnt = 0; m_armq = 1'b0; m_fresh = 1'b1;
            c_sel = 0; c_thr = 0; c_hyst = 0; c_hold = 0; c_edge = 1'b0; c_ss = 1'b0;
            foreach (pipe[i]) pipe[i] = 1'b0;
        end else begin
            lo  = c_thr - c_hyst;
            hi  = c_thr + c_hyst;
            pre = c_edge ? (m_s1 < lo) : (m_s1 > hi);
            crs = c_edge ? (m_s1 >= c_thr) : (m_s1 <= c_thr);
            nst = m_st;
            case (m_st)
                0: if (arm_v && !m_armq && !m_fresh) begin
                       c_sel = sel_v; c_thr = thr_v; c_hyst = hyst_v;
                       c_edge = edge_v; c_ss = ss_v; c_hold = hold_v;
                       nst = 1;
                   end
                1: if (pre) nst = 2;
                2: if (crs) begin
                       fire = 1'b1;
                       if (c_hold > 0) begin nst = 3; m_hcnt = c_hold - 1; end
                       else nst = c_ss ? 0 : 1;
                   end
                default: if (m_hcnt == 0) nst = c_ss ? 0 : 1; else m_hcnt--;
            endcase
            if (m_st != 0 && !arm_v) nst = 0;
            m_s1 = pick(m_st == 0 ? sel_v : c_sel);
            m_armq = arm_v; m_fresh = 1'b0; m_st = nst;
        end
        pipe.push_back(fire);
        @(posedge adc_clk);
        #1;
        cyc++;
        if (adc_rst) exp_cnt = 0;
        exp_trig = 1'b0;
        if (pipe.size() > 1) exp_trig = pipe.pop_front();
        if (exp_trig) exp_cnt++;
        check("trig_out", bus.trig_out, exp_trig);
        check("trig_cnt", bus.trig_cnt, exp_cnt);
        check("armed", bus.armed, (m_st == 1 || m_st == 2));
        if (bus.trig_out) begin
            pulses++;
            if (first_pulse < 0) first_pulse = cyc;
            if (last_pulse >= 0 && cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
            last_pulse = cyc;
        end
    endtask

    task automatic play0();
        foreach (seq[i]) begin ch0_v = seq[i]; step(); end
    endtask

    task automatic begin_scn();
        pulses = 0; first_pulse = -1; last_pulse = -1; min_gap = 1000;
    endtask

    task automatic set_cfg(input int s, input int t, input int h, input bit e, input bit ss, input int ho);
        sel_v = s; thr_v = t; hyst_v = h; edge_v = e; ss_v = ss; hold_v = ho;
    endtask

    task automatic disarm();
        arm_v = 1'b0;
        repeat (2) step();
    endtask

    task automatic arm_with(input int idle_val);
        ch0_v = idle_val;
        step();
        arm_v = 1'b1;
        step();
    endtask

    int c100;

    initial begin
        adc_rst = 1'b1; arm_v = 1'b1;
        set_cfg(0, 0, 0, 1'b1, 1'b0, 0);
        repeat (3) step();
        check("rst_trig_out", bus.trig_out, 0);
        check("rst_armed", bus.armed, 0);
        check("rst_trig_cnt", bus.trig_cnt, 0);
        adc_rst = 1'b0;
        repeat (3) step();
        check("arm_held_no_arm", bus.armed, 0);
        disarm();

        // rising ramp, auto re-arm
        set_cfg(0, 100, 10, 1'b1, 1'b0, 0);
        arm_with(80);
        begin_scn();
        seq = '{95, 100}; play0();
        c100 = cyc;
        seq = '{100, 100, 100, 100}; play0();
        check("ramp_pulses", pulses, 1);
        check("ramp_latency", first_pulse - c100, 2);
        check("ramp_cnt", bus.trig_cnt, 1);
        disarm();

        // hysteresis band blocks re-arm on 95
        arm_with(80);
        begin_scn();
        seq = '{100, 95, 100, 100, 100}; play0();
        check("hyst_pulses", pulses, 1);
        check("hyst_cnt", bus.trig_cnt, 2);
        disarm();

        // falling on ch1 with holdoff
        set_cfg(1, -200, 0, 1'b0, 1'b0, 5);
        ch1_v = -100;
        arm_with(0);
        begin_scn();
        for (int i = 0; i < 40; i++) begin
            ch1_v = ((i % 4) < 2) ? -100 : -300;
            ch0_v = int'($urandom_range(0, 8000));
            step();
        end
        check("square_pulses_ge3", pulses >= 3, 1);
        check("square_min_gap", min_gap, 8);
        disarm();
        ch1_v = 0;

        // single shot then re-arm
        set_cfg(0, 100, 10, 1'b1, 1'b1, 0);
        arm_with(80);
        begin_scn();
        seq = '{80, 120, 80, 120, 80, 120, 80, 80}; play0();
        check("ss_pulses", pulses, 1);
        check("ss_armed_after", bus.armed, 0);
        disarm();
        arm_with(80);
        begin_scn();
        seq = '{120, 80, 80, 80}; play0();
        check("ss_rearm_pulses", pulses, 1);
        disarm();

        // extreme threshold / hysteresis
        set_cfg(0, 8191, 8191, 1'b1, 1'b0, 0);
        arm_with(5);
        begin_scn();
        seq = '{-10, 8191, 8191, 8191, 8191}; play0();
        check("ovf_rise_pulses", pulses, 1);
        disarm();
        set_cfg(0, -8192, 8191, 1'b0, 1'b0, 0);
        arm_with(-5);
        begin_scn();
        seq = '{10, -8192, -8192, -8192, -8192}; play0();
        check("ovf_fall_pulses", pulses, 1);
        disarm();

        // abort in WAIT_CROSS
        set_cfg(0, 100, 10, 1'b1, 1'b0, 0);
        arm_with(80);
        begin_scn();
        ch0_v = 80; step();
        check("abort_armed_before", bus.armed, 1);
        arm_v = 1'b0;
        seq = '{120, 120, 120, 120}; play0();
        check("abort_pulses", pulses, 0);
        check("abort_armed_after", bus.armed, 0);

        // reset during holdoff
        set_cfg(0, 100, 10, 1'b1, 1'b0, 10);
        arm_with(80);
        seq = '{80, 120, 120, 120, 120, 120}; play0();
        adc_rst = 1'b1; step();
        check("rst_hold_trig_out", bus.trig_out, 0);
        check("rst_hold_armed", bus.armed, 0);
        check("rst_hold_cnt", bus.trig_cnt, 0);
        adc_rst = 1'b0;
        disarm();

        // reset while a pulse is in flight
        set_cfg(0, 100, 10, 1'b1, 1'b0, 0);
        arm_with(80);
        begin_scn();
        seq = '{80, 120, 120}; play0();
        adc_rst = 1'b1; step();
        adc_rst = 1'b0;
        repeat (3) step();
        check("rst_fire_pulses", pulses, 0);
        check("rst_fire_cnt", bus.trig_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
